ch0re_pipeline_core: RTL and testbench

//  In-order 5-stage RV64I core: IF, ID, EX, MEM, WB. Top of the core hierarchy.

---
 rtl/ch0re_pipeline_core.sv | 216 +++++++++++++++++++++
 tb/tb_ch0re_pipeline_core.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ch0re_pipeline_core.sv
// rtl/ch0re_pipeline_core.sv - in-order 5-stage RV64I core with private instruction/data memories
module ch0re_pipeline_core #(
  parameter string       IMEM_FILE  = "",
  parameter string       DMEM_FILE  = "",
  parameter logic [63:0] IMEM_START = 64'h100,
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024
) (
  input logic clk,
  input logic rst_n
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [3:0] {
    A_ADD = 4'b0000, A_SUB = 4'b1000, A_SLL = 4'b0001, A_SLT = 4'b0010, A_SLTU = 4'b0011,
    A_XOR = 4'b0100, A_SRL = 4'b0101, A_SRA = 4'b1101, A_OR = 4'b0110, A_AND = 4'b0111
  } alu_op_e;
  typedef enum logic [1:0] {LSU_NONE, LSU_LOAD, LSU_STORE} lsu_e;
  typedef enum logic [1:0] {CTL_NONE, CTL_BR, CTL_JAL, CTL_JALR} ctl_e;
  typedef enum logic [1:0] {M1_RS1, M1_PC, M1_ZERO} m1_e;
  typedef enum logic [1:0] {M2_RS2, M2_IMM, M2_FOUR} m2_e;

  typedef struct packed { logic dis; logic [63:0] pc; logic [31:0] ir; } ifid_t;
  typedef struct packed {
    logic dis; logic [63:0] pc; logic [4:0] rs1, rs2, rd;
    logic [63:0] a, b, imm; alu_op_e op; m1_e m1; m2_e m2; logic word;
    lsu_e lsu; logic [2:0] f3; ctl_e ctl; logic wen;
  } idex_t;
  typedef struct packed {
    logic dis; logic [4:0] rd; logic wen; lsu_e lsu; logic [2:0] f3;
    logic [63:0] alu_out, st_data;
  } exmem_t;
  typedef struct packed {
    logic dis; logic [4:0] rd; logic wen; lsu_e lsu; logic [2:0] f3; logic [63:0] alu_out;
  } memwb_t;

  logic [31:0] imem [IMEM_DEPTH];
  logic [63:0] dmem [DMEM_DEPTH];
  logic [63:0] rf [32];
  logic [63:0] pcr, mem_rdata;
  ifid_t  ifidr;
  idex_t  idexr, dec;
  exmem_t exmemr;
  memwb_t memwbr;
  logic   stallr;

  // WB: lane select by address offset, then sign/zero extension by funct3
  logic [63:0] ld_sh, ld_val, wb_data;
  logic        wb_we;
  always_comb begin
    ld_sh = mem_rdata >> {memwbr.alu_out[2:0], 3'b000};
    case (memwbr.f3)
      3'b000:  ld_val = {{56{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_val = {{48{ld_sh[15]}}, ld_sh[15:0]};
      3'b010:  ld_val = {{32{ld_sh[31]}}, ld_sh[31:0]};
      3'b100:  ld_val = {56'd0, ld_sh[7:0]};
      3'b101:  ld_val = {48'd0, ld_sh[15:0]};
      3'b110:  ld_val = {32'd0, ld_sh[31:0]};
      default: ld_val = ld_sh;
    endcase
    wb_data = (memwbr.lsu == LSU_LOAD) ? ld_val : memwbr.alu_out;
    wb_we   = memwbr.wen && !memwbr.dis && (memwbr.rd != 5'd0);
  end

  // ID: decode plus write-first register read
  logic [31:0] ir;
  logic        use1, use2, stall;
  assign ir = ifidr.ir;
  always_comb begin
    dec     = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    dec.pc  = ifidr.pc;
    dec.rs1 = ir[19:15];
    dec.rs2 = ir[24:20];
    dec.rd  = ir[11:7];
    dec.f3  = ir[14:12];
    case (ir[6:0])
      7'b0110111: begin dec.imm = {{32{ir[31]}}, ir[31:12], 12'd0}; dec.m1 = M1_ZERO; dec.m2 = M2_IMM; dec.wen = 1'b1; end
      7'b0010111: begin dec.imm = {{32{ir[31]}}, ir[31:12], 12'd0}; dec.m1 = M1_PC; dec.m2 = M2_IMM; dec.wen = 1'b1; end
      7'b1101111: begin
        dec.imm = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        dec.m1 = M1_PC; dec.m2 = M2_FOUR; dec.ctl = CTL_JAL; dec.wen = 1'b1;
      end
      7'b1100111: begin
        dec.imm = {{52{ir[31]}}, ir[31:20]};
        dec.m1 = M1_PC; dec.m2 = M2_FOUR; dec.ctl = CTL_JALR; dec.wen = 1'b1; use1 = 1'b1;
      end
      7'b1100011: begin
        dec.imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        dec.ctl = CTL_BR; use1 = 1'b1; use2 = 1'b1;
      end
      7'b0000011: begin dec.imm = {{52{ir[31]}}, ir[31:20]}; dec.m2 = M2_IMM; dec.lsu = LSU_LOAD; dec.wen = 1'b1; use1 = 1'b1; end
      7'b0100011: begin
        dec.imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
        dec.m2 = M2_IMM; dec.lsu = LSU_STORE; use1 = 1'b1; use2 = 1'b1;
      end
      7'b0010011, 7'b0011011: begin
        dec.imm = {{52{ir[31]}}, ir[31:20]}; dec.m2 = M2_IMM;
        dec.op = alu_op_e'({(ir[14:12] == 3'b101) && ir[30], ir[14:12]});
        dec.word = ir[3]; dec.wen = 1'b1; use1 = 1'b1;
      end
      7'b0110011, 7'b0111011: begin
        dec.op = alu_op_e'({ir[30], ir[14:12]});
        dec.word = ir[3]; dec.wen = 1'b1; use1 = 1'b1; use2 = 1'b1;
      end
      default: ;
    endcase
    dec.a = (wb_we && memwbr.rd == dec.rs1) ? wb_data : rf[dec.rs1];
    dec.b = (wb_we && memwbr.rd == dec.rs2) ? wb_data : rf[dec.rs2];
    stall = !ifidr.dis && !idexr.dis && idexr.lsu == LSU_LOAD && idexr.rd != 5'd0 &&
            ((use1 && idexr.rd == dec.rs1) || (use2 && idexr.rd == dec.rs2));
  end

  // EX: forwarding, ALU and branch resolution
  logic        ex_fwd, taken, cond;
  logic [63:0] rs1v, rs2v, opa, opb, res, alu_out, target;
  logic [5:0]  sh;
  always_comb begin
    ex_fwd = !exmemr.dis && exmemr.wen && exmemr.rd != 5'd0 && exmemr.lsu != LSU_LOAD;
    rs1v = (ex_fwd && exmemr.rd == idexr.rs1) ? exmemr.alu_out :
           (wb_we && memwbr.rd == idexr.rs1) ? wb_data : idexr.a;
    rs2v = (ex_fwd && exmemr.rd == idexr.rs2) ? exmemr.alu_out :
           (wb_we && memwbr.rd == idexr.rs2) ? wb_data : idexr.b;
    opa = (idexr.m1 == M1_PC) ? idexr.pc : (idexr.m1 == M1_ZERO) ? 64'd0 : rs1v;
    opb = (idexr.m2 == M2_IMM) ? idexr.imm : (idexr.m2 == M2_FOUR) ? 64'd4 : rs2v;
    sh  = idexr.word ? {1'b0, opb[4:0]} : opb[5:0];
    case (idexr.op)
      A_SUB:   res = opa - opb;
      A_SLL:   res = opa << sh;
      A_SLT:   res = {63'd0, $signed(opa) < $signed(opb)};
      A_SLTU:  res = {63'd0, opa < opb};
      A_XOR:   res = opa ^ opb;
      A_SRL:   res = idexr.word ? ({32'd0, opa[31:0]} >> sh) : (opa >> sh);
      A_SRA:   res = idexr.word ? ($signed({{32{opa[31]}}, opa[31:0]}) >>> sh) : ($signed(opa) >>> sh);
      A_OR:    res = opa | opb;
      A_AND:   res = opa & opb;
      default: res = opa + opb;
    endcase
    alu_out = idexr.word ? {{32{res[31]}}, res[31:0]} : res;
    case (idexr.f3)
      3'b000:  cond = rs1v == rs2v;
      3'b001:  cond = rs1v != rs2v;
      3'b100:  cond = $signed(rs1v) < $signed(rs2v);
      3'b101:  cond = $signed(rs1v) >= $signed(rs2v);
      3'b110:  cond = rs1v < rs2v;
      3'b111:  cond = rs1v >= rs2v;
      default: cond = 1'b0;
    endcase
    taken  = !idexr.dis && (idexr.ctl == CTL_JAL || idexr.ctl == CTL_JALR || (idexr.ctl == CTL_BR && cond));
    target = (idexr.ctl == CTL_JALR) ? ((rs1v + idexr.imm) & ~64'd1) : (idexr.pc + idexr.imm);
  end

  // MEM: lanes beyond byte 7 of the addressed dword are simply dropped
  logic [DAW-1:0] didx;
  logic [7:0]     be;
  logic [63:0]    wdata;
  always_comb begin
    didx = exmemr.alu_out[DAW+2:3];
    case (exmemr.f3[1:0])
      2'b00:   be = 8'h01;
      2'b01:   be = 8'h03;
      2'b10:   be = 8'h0F;
      default: be = 8'hFF;
    endcase
    be    = be << exmemr.alu_out[2:0];
    wdata = exmemr.st_data << {exmemr.alu_out[2:0], 3'b000};
  end

  always_ff @(posedge clk) begin
    if (!exmemr.dis && exmemr.lsu == LSU_STORE)
      for (int i = 0; i < 8; i++)
        if (be[i]) dmem[didx][8*i +: 8] <= wdata[8*i +: 8];
    mem_rdata <= dmem[didx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcr <= IMEM_START;
      ifidr <= '0;  ifidr.dis <= 1'b1;
      idexr <= '0;  idexr.dis <= 1'b1;
      exmemr <= '0; exmemr.dis <= 1'b1;
      memwbr <= '0; memwbr.dis <= 1'b1;
      stallr <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (taken)       pcr <= target;
      else if (!stall) pcr <= pcr + 64'd4;
      if (taken)       ifidr.dis <= 1'b1;
      else if (!stall) ifidr <= {1'b0, pcr, imem[pcr[IAW+1:2]]};
      // A taken branch squashes the ID op outright, so a pending stall is dropped with it
      if (taken || stall || ifidr.dis) begin
        idexr <= '0;
        idexr.dis <= 1'b1;
      end else begin
        idexr <= dec;
      end
      stallr <= stall && !taken;
      exmemr.dis     <= idexr.dis;
      exmemr.rd      <= idexr.rd;
      exmemr.wen     <= idexr.wen;
      exmemr.lsu     <= idexr.lsu;
      exmemr.f3      <= idexr.f3;
      exmemr.alu_out <= alu_out;
      exmemr.st_data <= rs2v;
      memwbr.dis     <= exmemr.dis;
      memwbr.rd      <= exmemr.rd;
      memwbr.wen     <= exmemr.wen;
      memwbr.lsu     <= exmemr.lsu;
      memwbr.f3      <= exmemr.f3;
      memwbr.alu_out <= exmemr.alu_out;
      if (wb_we) rf[memwbr.rd] <= wb_data;
    end
  end
endmodule

// File: tb/tb_ch0re_pipeline_core.sv
// tb/tb_ch0re_pipeline_core.sv - directed program bench for ch0re_pipeline_core
module tb_ch0re_pipeline_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  logic [31:0] prog [$];
  logic [63:0] acc;

  always #5 clk = ~clk;

  ch0re_pipeline_core #(.IMEM_START(64'h100)) dut (.clk(clk), .rst_n(rst_n));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd, input logic [6:0] op);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[19:0], 5'(rd), 7'h37};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0000_0013;
    for (int i = 0; i < prog.size(); i++) dut.imem[64 + i] = prog[i];
  endtask
  task automatic hold_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic release_reset();
    @(negedge clk) rst_n = 1'b1;
    #1;
  endtask
  task automatic run(input int n);
    stalls = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (dut.stallr) stalls++;
    end
  endtask

  initial begin
    // back-to-back ALU dependences and assorted ALU ops
    prog = '{addi(1, 0, 5), addi(2, 1, 7), enc_r(0, 2, 1, 0, 3, 7'h33),
             addi(4, 0, -1), enc_i(60, 4, 5, 5, 7'h13), enc_i(12'h404, 4, 5, 6, 7'h13),
             enc_r(0, 4, 0, 3, 7, 7'h33), enc_r(0, 0, 4, 2, 8, 7'h33),
             enc_u(20'h80000, 9), enc_i(-1, 9, 0, 9, 7'h1B), enc_r(32, 5, 0, 0, 11, 7'h33)};
    load_prog();
    hold_reset();
    release_reset();
    run(40);
    chk("fwd_x1", dut.rf[1], 64'd5);
    chk("fwd_x2", dut.rf[2], 64'd12);
    chk("fwd_x3", dut.rf[3], 64'd17);
    chk("srli", dut.rf[5], 64'hF);
    chk("srai", dut.rf[6], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sltu", dut.rf[7], 64'd1);
    chk("slt", dut.rf[8], 64'd1);
    chk("lui_addiw_wrap", dut.rf[9], 64'h0000_0000_7FFF_FFFF);
    chk("sub", dut.rf[11], 64'hFFFF_FFFF_FFFF_FFF1);
    chk("alu_no_stall", 64'(stalls), 64'd0);

    // reset state, then back-to-back loads into one add
    prog = '{addi(10, 0, 3), enc_s(0, 10, 0, 3), addi(10, 0, 4), enc_s(8, 10, 0, 3),
             enc_i(0, 0, 3, 1, 7'h03), enc_i(8, 0, 3, 2, 7'h03), enc_r(0, 2, 1, 0, 3, 7'h33)};
    load_prog();
    hold_reset();
    chk("rst_pcr", dut.pcr, 64'h100);
    chk("rst_ifid_dis", 64'(dut.ifidr.dis), 64'd1);
    chk("rst_idex_dis", 64'(dut.idexr.dis), 64'd1);
    chk("rst_exmem_dis", 64'(dut.exmemr.dis), 64'd1);
    chk("rst_memwb_dis", 64'(dut.memwbr.dis), 64'd1);
    chk("rst_wen", 64'({dut.idexr.wen, dut.exmemr.wen, dut.memwbr.wen}), 64'd0);
    chk("rst_stallr", 64'(dut.stallr), 64'd0);
    acc = '0;
    for (int i = 1; i < 32; i++) acc |= dut.rf[i];
    chk("rst_rf_zero", acc, 64'd0);
    release_reset();
    chk("first_pcr", dut.pcr, 64'h100);
    @(posedge clk);
    #1;
    chk("second_pcr", dut.pcr, 64'h104);
    run(40);
    chk("ld_x1", dut.rf[1], 64'd3);
    chk("ld_x2", dut.rf[2], 64'd4);
    chk("load_use_sum", dut.rf[3], 64'd7);
    chk("load_use_one_stall", 64'(stalls), 64'd1);

    // byte store into a known dword, then signed/unsigned and misaligned loads
    prog = '{enc_u(20'h11223, 10), addi(10, 10, 12'h344), enc_i(32, 10, 1, 11, 7'h13),
             enc_r(0, 11, 10, 6, 10, 7'h33), enc_s(0, 10, 0, 3), addi(12, 0, 12'h080),
             enc_s(5, 12, 0, 0), enc_i(5, 0, 0, 13, 7'h03), enc_i(5, 0, 4, 14, 7'h03),
             enc_i(5, 0, 1, 15, 7'h03), enc_i(0, 0, 3, 16, 7'h03), enc_i(6, 0, 2, 17, 7'h03),
             enc_i(7, 0, 5, 18, 7'h03)};
    load_prog();
    hold_reset();
    release_reset();
    run(40);
    chk("pattern", dut.rf[10], 64'h1122_3344_1122_3344);
    chk("lb_sext", dut.rf[13], 64'hFFFF_FFFF_FFFF_FF80);
    chk("lbu_zext", dut.rf[14], 64'h80);
    chk("lh_at_5", dut.rf[15], 64'h2280);
    chk("sb_other_lanes", dut.rf[16], 64'h1122_8044_1122_3344);
    chk("lw_misaligned", dut.rf[17], 64'h1122);
    chk("lhu_byte7", dut.rf[18], 64'h11);
    chk("mem_no_stall", 64'(stalls), 64'd0);

    // control flow: taken beq, jal link, x0 write, not-taken bne, jalr bit0 clear, pass loop
    prog = '{addi(5, 0, 1), enc_b(12, 0, 0, 0), addi(5, 0, 2), addi(5, 0, 3),
             enc_j(8, 6), addi(5, 0, 4), addi(0, 0, 9), enc_b(8, 0, 0, 1),
             addi(7, 0, 7), enc_i(12'h131, 0, 0, 8, 7'h67), addi(7, 0, 8), addi(7, 0, 9),
             addi(9, 0, 5), addi(28, 0, 5), addi(29, 0, 1), enc_j(0, 0)};
    load_prog();
    hold_reset();
    release_reset();
    run(60);
    chk("beq_skips", dut.rf[5], 64'd1);
    chk("jal_link", dut.rf[6], 64'h114);
    chk("x0_zero", dut.rf[0], 64'd0);
    chk("bne_not_taken", dut.rf[7], 64'd7);
    chk("jalr_link", dut.rf[8], 64'h128);
    chk("jalr_target", dut.rf[9], 64'd5);
    chk("test_id_x28", dut.rf[28], 64'd5);
    chk("pass_flag", dut.rf[29], 64'd1);
    chk("pass_loop_pc", 64'((dut.pcr >= 64'h13C) && (dut.pcr <= 64'h144)), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
